// File: rtl/l2trans_tx.sv
// L2 transaction transmit path: per-channel store-and-forward beat buffers
// feeding a message-granular arbiter onto the system bus transmit port.

module l2trans_tx_chan #(
  parameter int DEPTH = 32,
  parameter int HW    = 30
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  input  logic                   in_single_i,
  input  logic [HW-1:0]          in_hdr_i,
  input  logic [63:0]            in_data_i,
  input  logic                   pop_i,
  output logic                   out_last_o,
  output logic [HW-1:0]          out_hdr_o,
  output logic [63:0]            out_data_o,
  output logic [$clog2(DEPTH):0] occ_o,
  output logic                   msg_avail_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + HW + 64;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   occ_q, occ_d, msg_q, msg_d;
  logic [2:0]    beat_q, beat_d;
  logic [HW-1:0] hdr_q, hdr_d;
  logic          first, last_w, head_last;
  logic [HW-1:0] hdr_w;
  logic [63:0]   data_w;

  always_comb begin
    first     = (beat_q == 3'd0);
    last_w    = first ? in_single_i : (beat_q == 3'd7);
    hdr_w     = first ? in_hdr_i : hdr_q;
    // Single-beat messages carry no payload; store zero so the bus sees zero.
    data_w    = (first && in_single_i) ? '0 : in_data_i;
    head_last = mem_q[rp_q][EW-1];
    beat_d    = beat_q;
    hdr_d     = hdr_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    occ_d     = occ_q;
    msg_d     = msg_q;
    if (in_valid_i) begin
      beat_d = last_w ? '0 : beat_q + 3'd1;
      hdr_d  = hdr_w;
      wp_d   = wp_q + AW'(1);
    end
    if (pop_i) rp_d = rp_q + AW'(1);
    case ({in_valid_i, pop_i})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    case ({in_valid_i && last_w, pop_i && head_last})
      2'b10:   msg_d = msg_q + (AW+1)'(1);
      2'b01:   msg_d = msg_q - (AW+1)'(1);
      default: msg_d = msg_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (in_valid_i) mem_q[wp_q] <= {last_w, hdr_w, data_w};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q   <= '0;
      rp_q   <= '0;
      occ_q  <= '0;
      msg_q  <= '0;
      beat_q <= '0;
      hdr_q  <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      occ_q  <= occ_d;
      msg_q  <= msg_d;
      beat_q <= beat_d;
      hdr_q  <= hdr_d;
    end
  end

  assign out_last_o  = head_last;
  assign out_hdr_o   = mem_q[rp_q][EW-2:64];
  assign out_data_o  = mem_q[rp_q][63:0];
  assign occ_o       = occ_q;
  assign msg_avail_o = (msg_q != '0);
endmodule

module l2trans_tx #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l2data_req_valid,
  input  logic        l2data_req_noinv,
  input  logic [2:0]  l2data_req_cmd,
  input  logic [25:0] l2data_req_addr,
  input  logic [63:0] l2data_req_data,
  output logic        l2trans_l2data_req_ready,
  input  logic        l2data_snoop_valid,
  input  logic [4:0]  l2data_snoop_tag,
  input  logic [25:0] l2data_snoop_addr,
  input  logic [63:0] l2data_snoop_data,
  output logic        l2trans_l2data_snoop_ready,
  output logic        bus_tx_valid,
  input  logic        bus_tx_ready,
  output logic        bus_tx_snoop,
  output logic [2:0]  bus_tx_cmd,
  output logic        bus_tx_noinv,
  output logic [4:0]  bus_tx_tag,
  output logic [25:0] bus_tx_addr,
  output logic [63:0] bus_tx_data,
  output logic        bus_tx_last,
  output logic        l2trans_tx_idle
);
  // Command encoding: BUSRD=1, BUSRDX=2, BUSUPGR=3, FLUSH=4.
  localparam logic [2:0] CMD_FLUSH = 3'd4;
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MIN_FREE = (AW+1)'(16);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        prio_q, prio_d;
  logic        sel, tx_valid, head_last, req_pop, snp_pop;
  logic        req_last, snp_last, req_avail, snp_avail;
  logic [29:0] req_hdr;
  logic [30:0] snp_hdr;
  logic [63:0] req_data, snp_data;
  logic [AW:0] req_occ, snp_occ;

  l2trans_tx_chan #(.DEPTH(DEPTH), .HW(30)) u_req (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (l2data_req_valid),
    .in_single_i(l2data_req_cmd != CMD_FLUSH),
    .in_hdr_i   ({l2data_req_cmd, l2data_req_noinv, l2data_req_addr}),
    .in_data_i  (l2data_req_data),
    .pop_i      (req_pop),
    .out_last_o (req_last),
    .out_hdr_o  (req_hdr),
    .out_data_o (req_data),
    .occ_o      (req_occ),
    .msg_avail_o(req_avail)
  );

  l2trans_tx_chan #(.DEPTH(DEPTH), .HW(31)) u_snp (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (l2data_snoop_valid),
    .in_single_i(1'b0),
    .in_hdr_i   ({l2data_snoop_tag, l2data_snoop_addr}),
    .in_data_i  (l2data_snoop_data),
    .pop_i      (snp_pop),
    .out_last_o (snp_last),
    .out_hdr_o  (snp_hdr),
    .out_data_o (snp_data),
    .occ_o      (snp_occ),
    .msg_avail_o(snp_avail)
  );

  // The grant locks as soon as a head beat is presented, so a stalled beat
  // cannot be replaced by the other channel's message arriving later.
  always_comb begin
    if (state_q == ST_BUSY)        sel = grant_q;
    else if (req_avail && snp_avail) sel = prio_q;
    else                           sel = snp_avail;
    tx_valid  = (state_q == ST_BUSY) || req_avail || snp_avail;
    head_last = sel ? snp_last : req_last;
    req_pop   = tx_valid && bus_tx_ready && !sel;
    snp_pop   = tx_valid && bus_tx_ready && sel;
    state_d   = (tx_valid && !(bus_tx_ready && head_last)) ? ST_BUSY : ST_IDLE;
    grant_d   = tx_valid ? sel : grant_q;
    prio_d    = prio_q;
    if (state_q == ST_IDLE && req_avail && snp_avail) prio_d = ~sel;

    bus_tx_valid = tx_valid;
    bus_tx_snoop = 1'b0;
    bus_tx_cmd   = '0;
    bus_tx_noinv = 1'b0;
    bus_tx_tag   = '0;
    bus_tx_addr  = '0;
    bus_tx_data  = '0;
    bus_tx_last  = 1'b0;
    if (tx_valid) begin
      bus_tx_last = head_last;
      if (sel) begin
        bus_tx_snoop = 1'b1;
        bus_tx_tag   = snp_hdr[30:26];
        bus_tx_addr  = snp_hdr[25:0];
        bus_tx_data  = snp_data;
      end else begin
        bus_tx_cmd   = req_hdr[29:27];
        bus_tx_noinv = req_hdr[26];
        bus_tx_addr  = req_hdr[25:0];
        bus_tx_data  = req_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  assign l2trans_l2data_req_ready   = (DEPTH_V - req_occ) >= MIN_FREE;
  assign l2trans_l2data_snoop_ready = (DEPTH_V - snp_occ) >= MIN_FREE;
  assign l2trans_tx_idle = (req_occ == '0) && (snp_occ == '0) && (state_q == ST_IDLE);
endmodule

// File: tb/tb_l2trans_tx.sv
// Randomized and directed bench for l2trans_tx against a queue-based message model.

module tb_l2trans_tx;
  localparam int DEPTH = 32;
  localparam logic [2:0] CMD_BUSRD = 3'd1;
  localparam logic [2:0] CMD_FLUSH = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        l2data_req_valid = 1'b0, l2data_req_noinv = 1'b0;
  logic [2:0]  l2data_req_cmd = '0;
  logic [25:0] l2data_req_addr = '0;
  logic [63:0] l2data_req_data = '0;
  logic        l2trans_l2data_req_ready;
  logic        l2data_snoop_valid = 1'b0;
  logic [4:0]  l2data_snoop_tag = '0;
  logic [25:0] l2data_snoop_addr = '0;
  logic [63:0] l2data_snoop_data = '0;
  logic        l2trans_l2data_snoop_ready;
  logic        bus_tx_valid, bus_tx_ready = 1'b1, bus_tx_snoop;
  logic [2:0]  bus_tx_cmd;
  logic        bus_tx_noinv;
  logic [4:0]  bus_tx_tag;
  logic [25:0] bus_tx_addr;
  logic [63:0] bus_tx_data;
  logic        bus_tx_last, l2trans_tx_idle;

  always #5 clk = ~clk;

  l2trans_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .l2data_req_valid(l2data_req_valid), .l2data_req_noinv(l2data_req_noinv),
    .l2data_req_cmd(l2data_req_cmd), .l2data_req_addr(l2data_req_addr),
    .l2data_req_data(l2data_req_data), .l2trans_l2data_req_ready(l2trans_l2data_req_ready),
    .l2data_snoop_valid(l2data_snoop_valid), .l2data_snoop_tag(l2data_snoop_tag),
    .l2data_snoop_addr(l2data_snoop_addr), .l2data_snoop_data(l2data_snoop_data),
    .l2trans_l2data_snoop_ready(l2trans_l2data_snoop_ready),
    .bus_tx_valid(bus_tx_valid), .bus_tx_ready(bus_tx_ready), .bus_tx_snoop(bus_tx_snoop),
    .bus_tx_cmd(bus_tx_cmd), .bus_tx_noinv(bus_tx_noinv), .bus_tx_tag(bus_tx_tag),
    .bus_tx_addr(bus_tx_addr), .bus_tx_data(bus_tx_data), .bus_tx_last(bus_tx_last),
    .l2trans_tx_idle(l2trans_tx_idle)
  );

  typedef struct {
    logic        snoop;
    logic [2:0]  cmd;
    logic        noinv;
    logic [4:0]  tag;
    logic [25:0] addr;
    logic [63:0] data;
    logic [63:0] din;
    logic        last;
    logic        first;
    int          idx;
  } beat_t;

  beat_t pend_r[$], pend_s[$], exp_r[$], exp_s[$];
  int    done_r, done_s;
  bit    busy, cur, fav;
  bit    dut_start;
  bit    dut_order[$];
  int    nerr = 0, nchk = 0;
  int    mode = 0;
  bit    rnd_en = 0, rst_on_snp3 = 0, rst_hit = 0, after_rst = 1, tog = 0;
  int    rst_cycles = 1;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [100:0] pack_beat(beat_t b);
    return {b.snoop, b.cmd, b.noinv, b.tag, b.addr, b.data, b.last};
  endfunction

  function automatic logic [100:0] dut_pack();
    return {bus_tx_snoop, bus_tx_cmd, bus_tx_noinv, bus_tx_tag, bus_tx_addr,
            bus_tx_data, bus_tx_last};
  endfunction

  function automatic void model_clear();
    pend_r.delete(); pend_s.delete(); exp_r.delete(); exp_s.delete();
    done_r = 0; done_s = 0; busy = 0; cur = 0; fav = 1; dut_start = 1;
  endfunction

  task automatic add_req(logic [2:0] cmd, logic noinv, logic [25:0] addr,
                         logic [63:0] base, bit rnd);
    beat_t b;
    int n = (cmd == CMD_FLUSH) ? 8 : 1;
    for (int i = 0; i < n; i++) begin
      b.snoop = 0; b.cmd = cmd; b.noinv = noinv; b.tag = '0; b.addr = addr;
      b.din   = (cmd != CMD_FLUSH || rnd) ? {$urandom, $urandom} : base + 64'(i);
      b.data  = (cmd == CMD_FLUSH) ? b.din : '0;
      b.first = (i == 0); b.last = (i == n - 1); b.idx = i;
      pend_r.push_back(b);
    end
  endtask

  task automatic add_snp(logic [4:0] tag, logic [25:0] addr, logic [63:0] base, bit rnd);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.snoop = 1; b.cmd = '0; b.noinv = 0; b.tag = tag; b.addr = addr;
      b.din   = rnd ? {$urandom, $urandom} : base + 64'(i);
      b.data  = b.din;
      b.first = (i == 0); b.last = (i == 7); b.idx = i;
      pend_s.push_back(b);
    end
  endtask

  task automatic drive_inputs();
    beat_t b;
    l2data_req_valid = 0;
    l2data_req_cmd   = 3'($urandom); l2data_req_noinv = 1'($urandom);
    l2data_req_addr  = 26'($urandom); l2data_req_data = {$urandom, $urandom};
    l2data_snoop_valid = 0;
    l2data_snoop_tag = 5'($urandom); l2data_snoop_addr = 26'($urandom);
    l2data_snoop_data = {$urandom, $urandom};
    if (pend_r.size() > 0 && (!pend_r[0].first || exp_r.size() <= DEPTH - 16)) begin
      b = pend_r.pop_front();
      l2data_req_valid = 1;
      if (b.first) begin
        l2data_req_cmd = b.cmd; l2data_req_noinv = b.noinv; l2data_req_addr = b.addr;
      end
      l2data_req_data = b.din;
      exp_r.push_back(b);
      if (b.last) done_r++;
    end
    if (pend_s.size() > 0 && (!pend_s[0].first || exp_s.size() <= DEPTH - 16)) begin
      b = pend_s.pop_front();
      l2data_snoop_valid = 1;
      if (b.first) begin
        l2data_snoop_tag = b.tag; l2data_snoop_addr = b.addr;
      end
      l2data_snoop_data = b.din;
      exp_s.push_back(b);
      if (b.last) done_s++;
    end
  endtask

  task automatic step();
    bit    has, ch, rst_now, exp_idle;
    beat_t b, b2;
    @(negedge clk);
    has = 0; ch = 0;
    if (busy) begin has = 1; ch = cur; end
    else if (done_r > 0 && done_s > 0) begin has = 1; ch = fav; end
    else if (done_s > 0) begin has = 1; ch = 1; end
    else if (done_r > 0) begin has = 1; ch = 0; end
    exp_idle = (exp_r.size() == 0) && (exp_s.size() == 0) && !busy;
    check("valid", bus_tx_valid, has);
    check("idle", l2trans_tx_idle, exp_idle);
    check("req_ready", l2trans_l2data_req_ready, (DEPTH - exp_r.size()) >= 16);
    check("snoop_ready", l2trans_l2data_snoop_ready, (DEPTH - exp_s.size()) >= 16);
    if (after_rst) begin
      check("rst_fields", dut_pack(), '0);
      after_rst = 0;
    end
    if (has) begin
      b = ch ? exp_s[0] : exp_r[0];
      if (ch) check("snoop_beat", dut_pack(), pack_beat(b));
      else    check("req_beat", dut_pack(), pack_beat(b));
      if (!busy) begin
        if (done_r > 0 && done_s > 0) fav = ~ch;
        busy = 1; cur = ch;
      end
    end
    rst_now = (rst_cycles > 0) || (rst_on_snp3 && has && ch && b.idx == 3);
    case (mode)
      0: bus_tx_ready = 1;
      1: bus_tx_ready = 0;
      2: begin tog = ~tog; bus_tx_ready = tog; end
      default: bus_tx_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (rst_now) begin
      rst = 1;
      if (rst_cycles > 0) rst_cycles--;
      else begin rst_hit = 1; rst_on_snp3 = 0; end
      model_clear();
      after_rst = 1;
      l2data_req_valid = 0; l2data_snoop_valid = 0;
    end else begin
      rst = 0;
      if (bus_tx_valid && bus_tx_ready) begin
        if (dut_start) dut_order.push_back(bus_tx_snoop);
        dut_start = bus_tx_last;
      end
      if (has && bus_tx_ready) begin
        if (ch) begin
          b2 = exp_s.pop_front();
          if (b2.last) begin done_s--; busy = 0; end
        end else begin
          b2 = exp_r.pop_front();
          if (b2.last) begin done_r--; busy = 0; end
        end
      end
      if (rnd_en) begin
        if (pend_r.size() == 0 && $urandom_range(0, 5) == 0)
          add_req(3'($urandom_range(1, 4)), 1'($urandom), 26'($urandom), '0, 1);
        if (pend_s.size() == 0 && $urandom_range(0, 11) == 0)
          add_snp(5'($urandom), 26'($urandom), '0, 1);
      end
      drive_inputs();
    end
  endtask

  task automatic drain(int max_cycles);
    int k = 0;
    while ((pend_r.size() > 0 || pend_s.size() > 0 || exp_r.size() > 0 ||
            exp_s.size() > 0 || busy) && k < max_cycles) begin
      step();
      k++;
    end
    step();
    check("drain_idle", {l2trans_tx_idle, k >= max_cycles}, 2'b10);
  endtask

  initial begin
    int base;
    model_clear();
    step();

    add_req(CMD_BUSRD, 0, 26'h0123456, '0, 0);
    drain(50);

    add_req(CMD_FLUSH, 0, 26'h0000abc, 64'h10, 0);
    drain(60);

    rst_cycles = 1;
    step();
    base = dut_order.size();
    add_snp(5'd5, 26'h1111111, 64'h100, 0);
    add_req(CMD_FLUSH, 1, 26'h2222222, 64'h200, 0);
    drain(100);
    add_snp(5'd5, 26'h1111112, 64'h300, 0);
    add_req(CMD_FLUSH, 0, 26'h2222223, 64'h400, 0);
    drain(100);
    check("arb_order", {dut_order[base], dut_order[base+1],
                        dut_order[base+2], dut_order[base+3]}, 4'b1001);

    mode = 1;
    for (int i = 0; i < 20; i++)
      add_req(3'($urandom_range(1, 3)), 1'($urandom), 26'($urandom), '0, 1);
    repeat (30) step();
    check("req_ready_stall", l2trans_l2data_req_ready, 1'b0);
    mode = 0;
    drain(100);

    mode = 2;
    add_req(CMD_FLUSH, 1, 26'h3333333, 64'h500, 0);
    repeat (3) step();
    add_snp(5'd17, 26'h0444444, 64'h600, 0);
    drain(200);

    mode = 0;
    add_snp(5'd9, 26'h0555555, 64'h700, 0);
    rst_on_snp3 = 1;
    drain(100);
    check("rst_mid_snoop", {rst_hit, l2trans_tx_idle}, 2'b11);
    rst_on_snp3 = 0;
    add_req(CMD_FLUSH, 0, 26'h0666666, 64'h800, 0);
    drain(60);

    rnd_en = 1;
    mode = 3;
    repeat (3000) step();
    rnd_en = 0;
    mode = 0;
    drain(1000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
